// File: rtl/int_adder_result_buf.sv
// Result stage after the registered adder: captures sum/cout, derives {N,Z,C,V}, queues in a FIFO.
// Latency: issue in T, push at edge ending T+1, res_valid in T+2. Backpressure: res_valid/res_ready; credits via issue_ready.
// Optional flag capture enabled by INT_ADDER_RB_FLAGS_EN (otherwise res_flags is tied to zero).
module int_adder_result_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  issue_en,
    input  logic                  issue_a_msb,
    input  logic                  issue_b_msb,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] add_sum,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [3:0]            res_flags,
    output logic                  err_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           count;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  pend_valid;
    logic [AW+1:0]         used;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    // Credit counts the in-flight adder result as well as queued entries.
    assign used        = {1'b0, count} + (AW+2)'(pend_valid);
    assign issue_ready = used < (AW+2)'(DEPTH);
    assign res_valid   = (count != '0);

    assign accept = issue_en & issue_ready & ~flush;
    assign push   = pend_valid & ~flush;
    assign pop    = res_valid & res_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend_valid <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            pend_valid <= accept;
            if (issue_en && !issue_ready && !flush)
                err_drop <= 1'b1;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            data_mem[wr_ptr] <= add_sum;
    end

    assign res_data = res_valid ? data_mem[rd_ptr] : '0;

`ifdef INT_ADDER_RB_FLAGS_EN
    logic       pend_a_msb;
    logic       pend_b_msb;
    logic [3:0] push_flags;
    logic [3:0] flag_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a_msb <= 1'b0;
            pend_b_msb <= 1'b0;
        end else if (accept) begin
            pend_a_msb <= issue_a_msb;
            pend_b_msb <= issue_b_msb;
        end
    end

    // Overflow: operands share a sign and the sum's sign differs from it.
    assign push_flags = {add_sum[DATA_WIDTH-1],
                         (add_sum == '0),
                         add_cout,
                         (pend_a_msb == pend_b_msb) & (add_sum[DATA_WIDTH-1] != pend_a_msb)};

    always_ff @(posedge clk) begin
        if (push)
            flag_mem[wr_ptr] <= push_flags;
    end

    assign res_flags = res_valid ? flag_mem[rd_ptr] : 4'b0;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{issue_a_msb, issue_b_msb, add_cout};
    assign res_flags          = 4'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && push)
            assert (count < (AW+1)'(DEPTH))
                else $error("int_adder_result_buf: push into full FIFO");
    end
`endif

endmodule
